fft4_input_framer: RTL and testbench

Streaming front end for the 4-point FFT core. Accepts packed complex samples one per cycle over a valid/ready handshake and groups them into 4-sample frames in a ping-pong buffer. It presents each completed frame on the core's parallel inputs, pulses the core's `start`, and holds the frame until the core's `done` rises. Buffering continues while the core is busy, so back-pressure appears only when both banks are full.

---
 rtl/fft4_input_framer.sv | 115 +++++++++++
 tb/tb_fft4_input_framer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft4_input_framer.sv
// Streaming front end for the 4-point FFT core: collects 4-sample frames in a
// ping-pong buffer and launches each completed frame on the core's parallel inputs.
module fft4_input_framer #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             s_valid,
   input  logic [WIDTH-1:0] s_data,
   output logic             s_ready,
   output logic [WIDTH-1:0] fft_in0,
   output logic [WIDTH-1:0] fft_in1,
   output logic [WIDTH-1:0] fft_in2,
   output logic [WIDTH-1:0] fft_in3,
   output logic             fft_start,
   input  logic             fft_done,
   output logic             busy,
   output logic [CNT_W-1:0] frame_cnt
);

   typedef enum logic [1:0] {IDLE, START, BUSY} state_t;

   state_t           state;
   logic [WIDTH-1:0] bank [2][4];
   logic             wr_bank;
   logic             rd_bank;
   logic [1:0]       wr_idx;
   logic [1:0]       full;
   logic             done_q;
   logic             accept;
   logic             launch;

   assign s_ready = !full[wr_bank];
   // flush wins over a same-cycle sample
   assign accept  = s_valid && s_ready && !flush;
   assign launch  = (state == IDLE) && full[rd_bank];
   assign busy    = (state != IDLE);

   // Sample storage carries no reset: validity is tracked solely by full[].
   always_ff @(posedge clk) begin
      if (accept)
         bank[wr_bank][wr_idx] <= s_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_bank <= 1'b0;
         wr_idx  <= 2'd0;
      end else if (flush) begin
         wr_idx <= 2'd0;
      end else if (accept) begin
         wr_idx <= wr_idx + 2'd1;
         if (wr_idx == 2'd3)
            wr_bank <= !wr_bank;
      end
   end

   // Launch and completion always touch different banks: a full bank refuses writes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full <= 2'b00;
      end else begin
         if (launch)
            full[rd_bank] <= 1'b0;
         if (accept && wr_idx == 2'd3)
            full[wr_bank] <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         rd_bank   <= 1'b0;
         fft_in0   <= '0;
         fft_in1   <= '0;
         fft_in2   <= '0;
         fft_in3   <= '0;
         fft_start <= 1'b0;
         frame_cnt <= '0;
         done_q    <= 1'b0;
      end else begin
         done_q <= fft_done;
         case (state)
            IDLE: begin
               if (launch) begin
                  fft_in0   <= bank[rd_bank][0];
                  fft_in1   <= bank[rd_bank][1];
                  fft_in2   <= bank[rd_bank][2];
                  fft_in3   <= bank[rd_bank][3];
                  rd_bank   <= !rd_bank;
                  fft_start <= 1'b1;
                  frame_cnt <= frame_cnt + 1'b1;
                  state     <= START;
               end
            end
            START: begin
               fft_start <= 1'b0;
               state     <= BUSY;
            end
            BUSY: begin
               // only a fresh rising edge completes; a level left high is ignored
               if (fft_done && !done_q)
                  state <= IDLE;
            end
            default: begin
               fft_start <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fft4_input_framer.sv
// Directed bench for fft4_input_framer: framing latency, ping-pong back-pressure,
// done-edge detection, flush, async reset and frame counter wrap (CNT_W=2).
module tb_fft4_input_framer;

   localparam int WIDTH = 32;
   localparam int CNT_W = 2;

   logic             clk;
   logic             rst;
   logic             flush;
   logic             s_valid;
   logic [WIDTH-1:0] s_data;
   logic             s_ready;
   logic [WIDTH-1:0] fft_in0;
   logic [WIDTH-1:0] fft_in1;
   logic [WIDTH-1:0] fft_in2;
   logic [WIDTH-1:0] fft_in3;
   logic             fft_start;
   logic             fft_done;
   logic             busy;
   logic [CNT_W-1:0] frame_cnt;

   int vectors     = 0;
   int miscompares = 0;
   int start_cnt   = 0;
   int start_base  = 0;

   fft4_input_framer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .s_valid  (s_valid),
      .s_data   (s_data),
      .s_ready  (s_ready),
      .fft_in0  (fft_in0),
      .fft_in1  (fft_in1),
      .fft_in2  (fft_in2),
      .fft_in3  (fft_in3),
      .fft_start(fft_start),
      .fft_done (fft_done),
      .busy     (busy),
      .frame_cnt(frame_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (fft_start === 1'b1)
         start_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] d);
      s_valid = 1'b1;
      s_data  = d;
      for (int i = 0; i < 50 && !s_ready; i++)
         step();
      check("send_ready", {31'd0, s_ready}, 32'd1);
      step();
      s_valid = 1'b0;
      $display("sample %h accepted at %0t", d, $time);
   endtask

   task automatic send_frame(input logic [31:0] first);
      for (int i = 0; i < 4; i++)
         send(first + i);
   endtask

   task automatic wait_start(input string tag);
      for (int i = 0; i < 20 && !fft_start; i++)
         step();
      check(tag, {31'd0, fft_start}, 32'd1);
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      fft_done = 1'b0;
      s_valid  = 1'b0;
      flush    = 1'b0;
      step();
      step();
      rst = 1'b0;
      start_base = start_cnt;
   endtask

   int wrap_exp [5] = '{1, 2, 3, 0, 1};

   initial begin
      rst      = 1'b1;
      flush    = 1'b0;
      s_valid  = 1'b0;
      s_data   = '0;
      fft_done = 1'b0;
      step();
      step();
      check("rst_ready", {31'd0, s_ready}, 32'd1);
      check("rst_in0", fft_in0, 32'd0);
      check("rst_in3", fft_in3, 32'd0);
      check("rst_start", {31'd0, fft_start}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_cnt", {30'd0, frame_cnt}, 32'd0);
      rst = 1'b0;
      start_base = start_cnt;

      // basic frame and launch latency
      send(32'h0001_0000);
      send(32'h0002_0000);
      send(32'h0003_0000);
      send(32'h0004_0000);
      check("t1_no_early_start", {31'd0, fft_start}, 32'd0);
      step();
      check("t1_start", {31'd0, fft_start}, 32'd1);
      check("t1_in0", fft_in0, 32'h0001_0000);
      check("t1_in1", fft_in1, 32'h0002_0000);
      check("t1_in2", fft_in2, 32'h0003_0000);
      check("t1_in3", fft_in3, 32'h0004_0000);
      check("t1_cnt", {30'd0, frame_cnt}, 32'd1);
      check("t1_busy", {31'd0, busy}, 32'd1);
      step();
      check("t1_start_low", {31'd0, fft_start}, 32'd0);
      step();
      check("t1_busy_hold", {31'd0, busy}, 32'd1);
      fft_done = 1'b1;
      step();
      check("t1_idle", {31'd0, busy}, 32'd0);
      fft_done = 1'b0;
      check("t1_one_pulse", start_cnt - start_base, 32'd1);

      // ping-pong back-pressure
      do_reset();
      for (int i = 1; i <= 12; i++)
         send(i);
      check("t2_ready_low", {31'd0, s_ready}, 32'd0);
      check("t2_cnt1", {30'd0, frame_cnt}, 32'd1);
      check("t2_in0_held", fft_in0, 32'd1);
      fft_done = 1'b1;
      step();
      check("t2_idle", {31'd0, busy}, 32'd0);
      check("t2_ready_still_low", {31'd0, s_ready}, 32'd0);
      step();
      fft_done = 1'b0;
      check("t2_start2", {31'd0, fft_start}, 32'd1);
      check("t2_in0", fft_in0, 32'd5);
      check("t2_in3", fft_in3, 32'd8);
      check("t2_cnt2", {30'd0, frame_cnt}, 32'd2);
      check("t2_ready_back", {31'd0, s_ready}, 32'd1);

      // fft_done held high across frames
      do_reset();
      send_frame(32'h100);
      wait_start("t3_start1");
      step();
      fft_done = 1'b1;
      step();
      check("t3_done1", {31'd0, busy}, 32'd0);
      send_frame(32'h200);
      wait_start("t3_start2");
      for (int i = 0; i < 5; i++)
         step();
      check("t3_level_ignored", {31'd0, busy}, 32'd1);
      fft_done = 1'b0;
      step();
      check("t3_fall_busy", {31'd0, busy}, 32'd1);
      fft_done = 1'b1;
      step();
      check("t3_rise_done", {31'd0, busy}, 32'd0);
      fft_done = 1'b0;

      // flush drops a partial frame and a coincident sample
      do_reset();
      send(32'h1);
      send(32'h2);
      s_valid = 1'b1;
      s_data  = 32'h3;
      flush   = 1'b1;
      step();
      flush   = 1'b0;
      s_valid = 1'b0;
      send_frame(32'hA);
      wait_start("t4_start");
      check("t4_in0", fft_in0, 32'hA);
      check("t4_in1", fft_in1, 32'hB);
      check("t4_in2", fft_in2, 32'hC);
      check("t4_in3", fft_in3, 32'hD);
      for (int i = 0; i < 6; i++)
         step();
      check("t4_one_launch", start_cnt - start_base, 32'd1);

      // asynchronous reset mid-BUSY with a pending full bank
      do_reset();
      send_frame(32'h1);
      send_frame(32'h5);
      #2 rst = 1'b1;
      #1;
      check("t5_ready", {31'd0, s_ready}, 32'd1);
      check("t5_in0", fft_in0, 32'd0);
      check("t5_start", {31'd0, fft_start}, 32'd0);
      check("t5_busy", {31'd0, busy}, 32'd0);
      check("t5_cnt", {30'd0, frame_cnt}, 32'd0);
      #1 rst = 1'b0;
      start_base = start_cnt;
      step();
      fft_done = 1'b1;
      step();
      fft_done = 1'b0;
      for (int i = 0; i < 8; i++)
         step();
      check("t5_no_start", start_cnt - start_base, 32'd0);
      send_frame(32'h11);
      wait_start("t5_start_new");
      check("t5_in0_new", fft_in0, 32'h11);
      check("t5_cnt_new", {30'd0, frame_cnt}, 32'd1);

      // frame counter wrap with a 2-bit counter
      do_reset();
      for (int f = 0; f < 5; f++) begin
         send_frame(32'h40 * (f + 1));
         wait_start("t6_start");
         check("t6_cnt", {30'd0, frame_cnt}, wrap_exp[f]);
         step();
         fft_done = 1'b1;
         step();
         fft_done = 1'b0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
